// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FIFO read port and the framed output stream for fifo_burst_reader.
// master = the burst reader, slave = the FIFO plus downstream sink around it.
interface fifo_burst_reader_if #(
  parameter int depth = 16,
  parameter int width = 16
);
  localparam int cnt_w = $clog2(depth) + 1;

  logic [cnt_w-1:0] fifo_cnt;
  logic             fifo_empty;
  logic [width-1:0] fifo_data_out;
  logic             fifo_read;
  logic [width-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_sop;
  logic             m_eop;

  modport master (
    input  fifo_cnt, fifo_empty, fifo_data_out, m_ready,
    output fifo_read, m_data, m_valid, m_sop, m_eop
  );

  modport slave (
    output fifo_cnt, fifo_empty, fifo_data_out, m_ready,
    input  fifo_read, m_data, m_valid, m_sop, m_eop
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains fixed-size bursts from a synchronous FIFO into a sop/eop framed valid/ready stream.
// Define FIFO_BURST_TIMEOUT_EN to flush partial bursts after `timeout` idle cycles.
module fifo_burst_reader #(
  parameter int depth   = 16,
  parameter int width   = 16,
  parameter int burst   = 4,
  parameter int timeout = 32
) (
  input logic clk,
  input logic rst_,
  fifo_burst_reader_if.master bus
);
  localparam int cnt_w = $clog2(depth) + 1;
  // An illegal configuration leaves the reader permanently idle rather than misframing.
  localparam bit cfg_ok = (burst >= 1) && (burst <= depth) && (timeout >= 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state_reg;
  logic [cnt_w-1:0]      rd_left_reg;
  logic [cnt_w-1:0]      tx_left_reg;
  logic                  inflight_reg;
  logic                  first_reg;
  logic                  head_reg;
  logic [1:0]            occ_reg;
  logic [1:0]            occ_next;
  logic [1:0][width-1:0] skid_word;

  logic       pop;
  logic       read;
  logic       tail;
  logic       start_full;
  logic [2:0] need;
  logic [2:0] room;

  assign pop        = (occ_reg != 2'd0) && bus.m_ready;
  assign need       = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign room       = 3'd2 + {2'b00, pop};
  assign read       = (state_reg == READ) && (rd_left_reg != '0) && !bus.fifo_empty && (need < room);
  assign tail       = (occ_reg == 2'd0) ? head_reg : ~head_reg;
  assign start_full = cfg_ok && (bus.fifo_cnt >= cnt_w'(burst));
  assign occ_next   = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};

  assign bus.fifo_read = read;
  assign bus.m_valid   = (occ_reg != 2'd0);
  assign bus.m_data    = skid_word[head_reg];
  assign bus.m_sop     = first_reg && (occ_reg != 2'd0);
  assign bus.m_eop     = (tx_left_reg == cnt_w'(1)) && (occ_reg != 2'd0);

  // The read gating keeps the tail slot free whenever a word lands.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
      logic [width-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (rst_) begin
          word_reg <= '0;
        end else if (inflight_reg && (tail == 1'(gi))) begin
          word_reg <= bus.fifo_data_out;
        end
      end
      assign skid_word[gi] = word_reg;
    end
  endgenerate

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int timer_w = $clog2(timeout + 1);
  logic [timer_w-1:0] timer_reg;
  logic               flush;

  assign flush = cfg_ok && (bus.fifo_cnt != '0) && !start_full && (timer_reg == timer_w'(timeout));

  always_ff @(posedge clk) begin
    if (rst_) begin
      timer_reg <= '0;
    end else if ((state_reg != IDLE) || (bus.fifo_cnt == '0) || start_full || flush) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg    <= IDLE;
      rd_left_reg  <= '0;
      tx_left_reg  <= '0;
      inflight_reg <= 1'b0;
      first_reg    <= 1'b0;
      head_reg     <= 1'b0;
      occ_reg      <= 2'd0;
    end else begin
      inflight_reg <= read;
      occ_reg      <= occ_next;
      if (pop) head_reg <= ~head_reg;
      if (read) rd_left_reg <= rd_left_reg - 1'b1;
      case (state_reg)
        IDLE: begin
          if (start_full) begin
            state_reg   <= READ;
            rd_left_reg <= cnt_w'(burst);
            tx_left_reg <= cnt_w'(burst);
            first_reg   <= 1'b1;
          end
`ifdef FIFO_BURST_TIMEOUT_EN
          else if (flush) begin
            state_reg   <= READ;
            rd_left_reg <= bus.fifo_cnt;
            tx_left_reg <= bus.fifo_cnt;
            first_reg   <= 1'b1;
          end
`endif
        end
        READ: begin
          if (pop) begin
            first_reg   <= 1'b0;
            tx_left_reg <= tx_left_reg - 1'b1;
            if (tx_left_reg == cnt_w'(1)) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-backed FIFO model feeds the reader,
// a monitor captures accepted words; cycle tables and packet checks compare against hand values.
module tb_fifo_burst_reader;
  localparam int depth = 16, width = 16, burst = 4, timeout = 32;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  fifo_burst_reader_if #(.depth(depth), .width(width)) bus ();

  fifo_burst_reader #(.depth(depth), .width(width), .burst(burst), .timeout(timeout)) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] push_base;
    logic        rdy;
    logic        read;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } vec_t;

  vec_t        tbl [17];
  logic [15:0] q [$];
  logic [17:0] rx_q [$];
  logic        force_empty = 1'b0;
  int          n_cmp = 0, n_fail = 0;
  int          rd_count = 0, outstanding = 0, max_out = 0, stall_err = 0, underflow = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_cnt   = 5'(q.size());
    bus.fifo_empty = (q.size() == 0) || force_empty;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + 16'(i));
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
  endtask

  task automatic check_rx(input string name, input logic [15:0] base, input int n, input int pkt);
    logic [17:0] e;
    check({name, " count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      e = {((i % pkt) == 0), ((i % pkt) == pkt - 1), base + 16'(i)};
      check($sformatf("%s word%0d", name, i), 32'(rx_q[i]), 32'(e));
    end
  endtask

  // FIFO model with one-cycle read latency, plus stream monitor.
  initial begin
    logic rd_s, acc;
    bus.fifo_data_out = '0;
    forever begin
      @(negedge clk);
      rd_s = bus.fifo_read;
      if (rst_) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (rd_s) rd_count++;
        acc = bus.m_valid && bus.m_ready;
        if (prev_stall && !(bus.m_valid && ({bus.m_sop, bus.m_eop, bus.m_data} == prev_word)))
          stall_err++;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_word  = {bus.m_sop, bus.m_eop, bus.m_data};
        if (acc) rx_q.push_back(prev_word);
        outstanding += int'(rd_s) - int'(acc);
        if (outstanding > max_out) max_out = outstanding;
      end
      tick();
      if (rd_s) begin
        if (q.size() == 0) underflow++;
        else bus.fifo_data_out = q.pop_front();
        refresh();
      end
    end
  end

  initial begin
    int k, forced_reads;
    // push_base, rdy, read, valid, sop, eop, data
    tbl[0]  = '{16'h0001, 1, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{16'h0000, 1, 1, 0, 0, 0, 16'h0000};
    tbl[2]  = '{16'h0000, 1, 1, 0, 0, 0, 16'h0000};
    tbl[3]  = '{16'h0000, 1, 1, 1, 1, 0, 16'h0001};
    tbl[4]  = '{16'h0000, 1, 1, 1, 0, 0, 16'h0002};
    tbl[5]  = '{16'h0000, 1, 0, 1, 0, 0, 16'h0003};
    tbl[6]  = '{16'h0000, 1, 0, 1, 0, 1, 16'h0004};
    tbl[7]  = '{16'h0000, 1, 0, 0, 0, 0, 16'h0000};
    tbl[8]  = '{16'h0011, 1, 0, 0, 0, 0, 16'h0000};
    tbl[9]  = '{16'h0000, 1, 1, 0, 0, 0, 16'h0000};
    tbl[10] = '{16'h0000, 1, 1, 0, 0, 0, 16'h0000};
    tbl[11] = '{16'h0000, 1, 1, 1, 1, 0, 16'h0011};
    tbl[12] = '{16'h0000, 0, 0, 1, 0, 0, 16'h0012};
    tbl[13] = '{16'h0000, 1, 1, 1, 0, 0, 16'h0012};
    tbl[14] = '{16'h0000, 1, 0, 1, 0, 0, 16'h0013};
    tbl[15] = '{16'h0000, 1, 0, 1, 0, 1, 16'h0014};
    tbl[16] = '{16'h0000, 1, 0, 0, 0, 0, 16'h0000};

    bus.m_ready = 1'b1;
    push_words(16'h0021, 8);

    // Reset held for two edges with a full FIFO.
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("reset outputs c%0d", i),
            {11'b0, bus.fifo_read, bus.m_valid, bus.m_sop, bus.m_eop, bus.m_data}, 32'h0);
      tick();
    end
    rst_ = 1'b0;
    @(negedge clk);
    check("read first cycle after reset", 32'(bus.fifo_read), 32'h0);
    tick();
    @(negedge clk);
    check("read second cycle after reset", 32'(bus.fifo_read), 32'h1);
    tick();
    wait_rx(8, 60);
    check_rx("post-reset drain", 16'h0021, 8, burst);
    repeat (3) tick();

    // Cycle-accurate tables: plain burst, then a burst with one stall cycle.
    rx_q.delete();
    rd_count = 0;
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].push_base != 16'h0) push_words(tbl[i].push_base, burst);
      bus.m_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("table row%0d", i),
            {12'b0, bus.fifo_read, bus.m_valid, bus.m_sop, bus.m_eop,
             tbl[i].valid ? bus.m_data : 16'h0},
            {12'b0, tbl[i].read, tbl[i].valid, tbl[i].sop, tbl[i].eop,
             tbl[i].valid ? tbl[i].data : 16'h0});
      tick();
    end
    check("table read pulses", 32'(rd_count), 32'd8);

    // Backpressure: ready toggles every cycle across two packets.
    rx_q.delete();
    max_out = 0;
    stall_err = 0;
    push_words(16'h0031, 8);
    for (int i = 0; i < 120 && rx_q.size() < 8; i++) begin
      bus.m_ready = ~bus.m_ready;
      tick();
    end
    bus.m_ready = 1'b1;
    check_rx("backpressure", 16'h0031, 8, burst);
    check("stall stability errors", 32'(stall_err), 32'd0);
    check("max buffered <= 2", 32'(max_out <= 2), 32'd1);
    repeat (3) tick();

    // Empty flag forced mid-READ stalls the reads.
    rx_q.delete();
    rd_count = 0;
    forced_reads = 0;
    push_words(16'h0041, 4);
    tick();
    tick();
    force_empty = 1'b1;
    refresh();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.fifo_read) forced_reads++;
      tick();
    end
    force_empty = 1'b0;
    refresh();
    check("reads while empty", 32'(forced_reads), 32'd0);
    wait_rx(4, 40);
    check_rx("empty resume", 16'h0041, 4, burst);
    check("empty test read pulses", 32'(rd_count), 32'd4);
    repeat (3) tick();

    // Reset after the second accepted word.
    rx_q.delete();
    push_words(16'h0051, 4);
    wait_rx(2, 40);
    check("mid-burst words before reset", 32'(rx_q.size()), 32'd2);
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    @(negedge clk);
    check("valid after mid-burst reset", {30'b0, bus.m_valid, bus.fifo_read}, 32'h0);
    tick();
    rx_q.delete();
    push_words(16'h0061, 4);
    wait_rx(4, 40);
    check_rx("packet after reset", 16'h0061, 4, burst);
    repeat (3) tick();

    // Below-threshold occupancy.
    rx_q.delete();
    rd_count = 0;
    push_words(16'h0071, 3);
`ifdef FIFO_BURST_TIMEOUT_EN
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_valid) break;
      k++;
      tick();
    end
    check("flush latency in window", 32'((k >= 30) && (k <= 40)), 32'd1);
    tick();
    wait_rx(3, 20);
    check_rx("partial flush", 16'h0071, 3, 3);
`else
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_valid || bus.fifo_read) k++;
      tick();
    end
    check("below threshold activity", 32'(k), 32'd0);
    check("below threshold reads", 32'(rd_count), 32'd0);
    check("below threshold fifo_cnt", 32'(bus.fifo_cnt), 32'd3);
`endif
    check("fifo underflow", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
